// File: rtl/edp_muldiv_pkg.sv
// edp_muldiv_pkg: shared types and helpers for the EBOX iterative multiply/divide engine.
//   muldiv_op_t    : operation code as driven by CTL microcode
//   muldiv_state_t : sequencer states
//   mag()          : magnitude of a two's-complement value of a given width
package edp_muldiv_pkg;

  typedef enum logic [1:0] {MULU = 2'b00, MUL = 2'b01, DIVU = 2'b10, DIV = 2'b11} muldiv_op_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} muldiv_state_t;

  // Widest value mag() can handle; callers zero-extend into this and slice back.
  localparam int MAG_MAX_W = 128;

  function automatic logic [MAG_MAX_W-1:0] mag(input logic [MAG_MAX_W-1:0] x,
                                               input int unsigned width,
                                               input logic signed_op);
    logic [MAG_MAX_W-1:0] mask;
    logic                 neg;
    mask = (MAG_MAX_W'(1) << width) - MAG_MAX_W'(1);
    neg  = |(x & (MAG_MAX_W'(1) << (width - 1)));
    if (signed_op && neg) return (~x + MAG_MAX_W'(1)) & mask;
    return x & mask;
  endfunction

  function automatic logic is_div_op(input muldiv_op_t op);
    return (op == DIVU) || (op == DIV);
  endfunction

  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == MUL) || (op == DIV);
  endfunction

endpackage

// File: rtl/edp_muldiv_step.sv
// edp_muldiv_step: one combinational sub-step of the AR/MQ iteration.
//   op         : selects shift-add multiply or non-restoring divide
//   ar_i, mq_i : current AR/MQ pair;  b_i : multiplicand / divisor magnitude
//   rem_sign_i : sign of the (W+1)-bit partial remainder (divide only)
//   ar_o, mq_o, rem_sign_o : values after this sub-step
module edp_muldiv_step
  import edp_muldiv_pkg::*;
#(
  parameter int W = 36
) (
  input  muldiv_op_t     op,
  input  logic [W-1:0]   ar_i,
  input  logic [W-1:0]   mq_i,
  input  logic [W-1:0]   b_i,
  input  logic           rem_sign_i,
  output logic [W-1:0]   ar_o,
  output logic [W-1:0]   mq_o,
  output logic           rem_sign_o
);

  logic [W:0] mul_sum;
  logic [W:0] div_sh;
  logic [W:0] div_res;

  always_comb begin
    mul_sum = {1'b0, ar_i} + (mq_i[0] ? {1'b0, b_i} : '0);
    // The partial remainder lives in (-B, B), so W+1 bits hold it exactly;
    // the doubled value may not, but modulo-2^(W+1) arithmetic still yields
    // the correct next remainder.
    div_sh  = {ar_i, mq_i[W-1]};
    div_res = rem_sign_i ? (div_sh + {1'b0, b_i}) : (div_sh - {1'b0, b_i});
    if (is_div_op(op)) begin
      ar_o       = div_res[W-1:0];
      rem_sign_o = div_res[W];
      mq_o       = {mq_i[W-2:0], ~div_res[W]};
    end else begin
      ar_o       = mul_sum[W:1];
      mq_o       = {mul_sum[0], mq_i[W-1:1]};
      rem_sign_o = 1'b0;
    end
  end

endmodule

// File: rtl/edp_muldiv_seq.sv
// edp_muldiv_seq: iterative multiply/divide engine for the EBOX data path.
//   clk, reset : EDP clock, synchronous active-high reset
//   start/abort: CTL handshake; op selects MULU/MUL/DIVU/DIV
//   in_hi/in_lo: dividend (2W) or multiplier (in_lo);  in_b: divisor / multiplicand
//   busy, done : busy from the cycle after accept until DONE is left; done pulses in DONE
//   no_divide  : divide overflow / divide by zero, valid with done
//   res_hi/lo  : product (hi:lo) or remainder:quotient, held until next result
module edp_muldiv_seq
  import edp_muldiv_pkg::*;
#(
  parameter int W    = 36,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [1:0]   op,
  input  logic [W-1:0] in_hi,
  input  logic [W-1:0] in_lo,
  input  logic [W-1:0] in_b,
  output logic         busy,
  output logic         done,
  output logic         no_divide,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo
);

  localparam int N  = W / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [W-1:0] Q_NEG_MAX = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] Q_POS_MAX = Q_NEG_MAX - W'(1);

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q, op_d;
  logic [W-1:0]  ar_q, ar_d, mq_q, mq_d, b_q, b_d;
  logic [W-1:0]  orig_hi_q, orig_hi_d, orig_lo_q, orig_lo_d;
  logic [W-1:0]  res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic          rem_sign_q, rem_sign_d, sgn_quo_q, sgn_quo_d, sgn_rem_q, sgn_rem_d;
  logic          no_div_q, no_div_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Sub-step chain: STEP copies retire STEP bits per RUN cycle.
  logic [STEP:0][W-1:0] ar_c, mq_c;
  logic [STEP:0]        rs_c;

  assign ar_c[0] = ar_q;
  assign mq_c[0] = mq_q;
  assign rs_c[0] = rem_sign_q;

  for (genvar g = 0; g < STEP; g++) begin : g_step
    edp_muldiv_step #(.W(W)) u_step (
      .op(op_q), .ar_i(ar_c[g]), .mq_i(mq_c[g]), .b_i(b_q), .rem_sign_i(rs_c[g]),
      .ar_o(ar_c[g+1]), .mq_o(mq_c[g+1]), .rem_sign_o(rs_c[g+1])
    );
  end

  // Operand magnitudes at accept time.
  muldiv_op_t           op_in;
  logic                 in_signed, in_div, a_sign, early_ovf;
  logic [MAG_MAX_W-1:0] b_mag_x, a_mag_x, dvd_mag_x;
  logic                 unused_mag_bits;

  always_comb begin
    op_in     = muldiv_op_t'(op);
    in_signed = is_signed_op(op_in);
    in_div    = is_div_op(op_in);
    a_sign    = in_div ? in_hi[W-1] : in_lo[W-1];
    b_mag_x   = mag(MAG_MAX_W'(in_b), unsigned'(W), in_signed);
    a_mag_x   = mag(MAG_MAX_W'(in_lo), unsigned'(W), in_signed);
    dvd_mag_x = mag(MAG_MAX_W'({in_hi, in_lo}), unsigned'(2 * W), in_signed);
    // Quotient can only fit in W bits when |hi| < |b|.
    early_ovf = in_div && ((in_b == '0) || (dvd_mag_x[2*W-1:W] >= b_mag_x[W-1:0]));
  end

  assign unused_mag_bits = ^{b_mag_x[MAG_MAX_W-1:W], a_mag_x[MAG_MAX_W-1:W],
                             dvd_mag_x[MAG_MAX_W-1:2*W]};

  // Post-iteration fix-up values.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   rem_fix, rem_out, quo_out;
  logic           q_ovf;

  always_comb begin
    prod_fix = sgn_quo_q ? -{ar_q, mq_q} : {ar_q, mq_q};
    rem_fix  = rem_sign_q ? (ar_q + b_q) : ar_q;   // undo the last non-restoring subtract
    rem_out  = sgn_rem_q ? -rem_fix : rem_fix;
    quo_out  = sgn_quo_q ? -mq_q : mq_q;
    q_ovf    = is_signed_op(op_q) && (mq_q > (sgn_quo_q ? Q_NEG_MAX : Q_POS_MAX));
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ar_d       = ar_q;
    mq_d       = mq_q;
    b_d        = b_q;
    rem_sign_d = rem_sign_q;
    sgn_quo_d  = sgn_quo_q;
    sgn_rem_d  = sgn_rem_q;
    orig_hi_d  = orig_hi_q;
    orig_lo_d  = orig_lo_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    no_div_d   = no_div_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: if (start && !abort) begin
        op_d       = op_in;
        orig_hi_d  = in_hi;
        orig_lo_d  = in_lo;
        b_d        = b_mag_x[W-1:0];
        ar_d       = in_div ? dvd_mag_x[2*W-1:W] : '0;
        mq_d       = in_div ? dvd_mag_x[W-1:0] : a_mag_x[W-1:0];
        rem_sign_d = 1'b0;
        sgn_quo_d  = in_signed & (a_sign ^ in_b[W-1]);
        sgn_rem_d  = in_signed & in_div & in_hi[W-1];
        if (early_ovf) begin
          state_d  = DONE;
          res_hi_d = in_hi;
          res_lo_d = in_lo;
          no_div_d = 1'b1;
        end else begin
          state_d = RUN;
          cnt_d   = CW'(N - 1);
        end
      end
      RUN: begin
        ar_d       = ar_c[STEP];
        mq_d       = mq_c[STEP];
        rem_sign_d = rs_c[STEP];
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        state_d  = DONE;
        no_div_d = 1'b0;
        if (!is_div_op(op_q)) begin
          res_hi_d = prod_fix[2*W-1:W];
          res_lo_d = prod_fix[W-1:0];
        end else if (q_ovf) begin
          res_hi_d = orig_hi_q;
          res_lo_d = orig_lo_q;
          no_div_d = 1'b1;
        end else begin
          res_hi_d = rem_out;
          res_lo_d = quo_out;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort drops the operation and leaves the visible results untouched.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      no_div_d = no_div_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= MULU;
      ar_q       <= '0;
      mq_q       <= '0;
      b_q        <= '0;
      rem_sign_q <= 1'b0;
      sgn_quo_q  <= 1'b0;
      sgn_rem_q  <= 1'b0;
      orig_hi_q  <= '0;
      orig_lo_q  <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      no_div_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ar_q       <= ar_d;
      mq_q       <= mq_d;
      b_q        <= b_d;
      rem_sign_q <= rem_sign_d;
      sgn_quo_q  <= sgn_quo_d;
      sgn_rem_q  <= sgn_rem_d;
      orig_hi_q  <= orig_hi_d;
      orig_lo_q  <= orig_lo_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      no_div_q   <= no_div_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign no_divide = no_div_q;
  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;

endmodule
